// File: rtl/irq_trap_req.sv
// rtl/irq_trap_req.sv - machine-level interrupt request generator for csr_fu
module irq_trap_req #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            ext_irq_in,
    input  logic            sw_irq_in,
    input  logic            timer_irq_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic            mstatus_mie_in,
    input  logic [1:0]      mode_in,
    input  logic            exc_flag_in,
    input  logic            trap_ack_in,
    output logic            trap_req_out,
    output logic [XLEN-1:0] trap_cause_out,
    output logic [XLEN-1:0] mip_out
);

    localparam int MEI_BIT = 11;
    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam logic [XLEN-1:0] IRQ_MASK =
        (XLEN'(1) << MEI_BIT) | (XLEN'(1) << MSI_BIT) | (XLEN'(1) << MTI_BIT);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   msip_q, mtip_q;
    logic                   global_en;
    logic [2:0]             cand;      // {MEI, MSI, MTI}, highest priority first
    logic [2:0]             sel_d, sel_q;
    logic [3:0]             code_d;
    logic                   sel_still_valid;
    logic                   unused_mie;
    logic [XLEN-1:0]        trap_cause_q;

    assign unused_mie = ^(mie_in & ~IRQ_MASK);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ext_sync <= '0;
            msip_q   <= 1'b0;
            mtip_q   <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq_in};
            msip_q   <= sw_irq_in;
            mtip_q   <= timer_irq_in;
        end
    end

    always_comb begin
        mip_out          = '0;
        mip_out[MEI_BIT] = ext_sync[SYNC_STAGES-1];
        mip_out[MSI_BIT] = msip_q;
        mip_out[MTI_BIT] = mtip_q;
    end

    // M-mode follows mstatus.MIE, U-mode is always enabled, modes 1 and 2 never enable.
    always_comb begin
        case (mode_in)
            2'd3:    global_en = mstatus_mie_in;
            2'd0:    global_en = 1'b1;
            default: global_en = 1'b0;
        endcase
    end

    assign cand = {mip_out[MEI_BIT] & mie_in[MEI_BIT],
                   mip_out[MSI_BIT] & mie_in[MSI_BIT],
                   mip_out[MTI_BIT] & mie_in[MTI_BIT]};

    always_comb begin
        sel_d  = 3'b000;
        code_d = 4'd0;
        if (cand[2]) begin
            sel_d  = 3'b100;
            code_d = 4'(MEI_BIT);
        end else if (cand[1]) begin
            sel_d  = 3'b010;
            code_d = 4'(MSI_BIT);
        end else if (cand[0]) begin
            sel_d  = 3'b001;
            code_d = 4'(MTI_BIT);
        end
    end

    assign sel_still_valid = (|(cand & sel_q)) & global_en;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack beats a same-cycle exception; otherwise any loss of the selected source withdraws.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if ((|cand) && global_en && !exc_flag_in) state_d = REQ;
            REQ: begin
                if (trap_ack_in)                          state_d = HOLD;
                else if (!sel_still_valid || exc_flag_in) state_d = IDLE;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trap_req_out   = (state_q == REQ);
        trap_cause_out = trap_cause_q;
    end

    // Cause and selection only change on IDLE->REQ, so the cause stays stable while requesting.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            trap_cause_q <= '0;
            sel_q        <= 3'b000;
        end else if (state_q == IDLE && state_d == REQ) begin
            trap_cause_q <= {1'b1, {(XLEN-5){1'b0}}, code_d};
            sel_q        <= sel_d;
        end
    end

endmodule
